gen_arbiter: RTL and testbench

//   Three-requester round-robin arbiter with grant lock. Grants at most one

---
 rtl/gen_arbiter.sv | 110 +++++++++++
 tb/tb_gen_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gen_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gen_arbiter
//  Description : Three-requester round-robin arbiter with grant lock.
//                A granted requester keeps the grant while it holds its
//                request; on release the grant rotates directly to the next
//                pending requester. Grants are decoded from a state register.
//  Revision    : 1.0  initial release
// ============================================================================
module gen_arbiter (
  input  logic clk,
  input  logic res_n,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  output logic grant0,
  output logic grant1,
  output logic grant2
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2,
    S_G2   = 2'd3
  } state_t;

  // Pointer value that makes requester 0 the first in rotation order.
  localparam logic [1:0] C_LAST_RESET = 2'd2;

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;

  logic [2:0] w_req;
  logic       w_any;
  logic       w_hold;
  logic [1:0] w_pick;

  assign w_req = {req2, req1, req0};
  assign w_any = |w_req;

  // First pending requester in rotation order after the last-granted one.
  // While in GN the pointer equals N, so this also yields the handover target.
  always_comb begin
    w_pick = 2'd0;
    case (last_q)
      2'd0: begin
        if (w_req[1])      w_pick = 2'd1;
        else if (w_req[2]) w_pick = 2'd2;
        else               w_pick = 2'd0;
      end
      2'd1: begin
        if (w_req[2])      w_pick = 2'd2;
        else if (w_req[0]) w_pick = 2'd0;
        else               w_pick = 2'd1;
      end
      default: begin
        if (w_req[0])      w_pick = 2'd0;
        else if (w_req[1]) w_pick = 2'd1;
        else               w_pick = 2'd2;
      end
    endcase
  end

  // Current holder still requesting: grant is locked.
  always_comb begin
    w_hold = 1'b0;
    case (state_q)
      S_G0:    w_hold = w_req[0];
      S_G1:    w_hold = w_req[1];
      S_G2:    w_hold = w_req[2];
      default: w_hold = 1'b0;
    endcase
  end

  // Next-state and pointer update: lock, rotate, or fall back to idle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (w_hold) begin
      state_d = state_q;
    end else if (w_any) begin
      last_d = w_pick;
      case (w_pick)
        2'd0:    state_d = S_G0;
        2'd1:    state_d = S_G1;
        default: state_d = S_G2;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // State and pointer registers; reset clears grants without a clock edge.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      last_q  <= C_LAST_RESET;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign grant0 = (state_q == S_G0);
  assign grant1 = (state_q == S_G1);
  assign grant2 = (state_q == S_G2);

endmodule
`default_nettype wire

// File: tb/tb_gen_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gen_arbiter
//  Description : Self-checking bench for gen_arbiter: directed sequence
//                followed by randomized requests against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gen_arbiter;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic grant0, grant1, grant2;
  logic [2:0] grant;
  logic [2:0] req_prev = 3'b000;

  int checks = 0;
  int failures = 0;

  // Reference model: holder index (-1 = none) and last-granted index.
  int m_holder = -1;
  int m_last = 2;

  assign grant = {grant2, grant1, grant0};

  always #5 clk = ~clk;

  gen_arbiter dut (
    .clk    (clk),
    .res_n  (res_n),
    .req0   (req[0]),
    .req1   (req[1]),
    .req2   (req[2]),
    .grant0 (grant0),
    .grant1 (grant1),
    .grant2 (grant2)
  );

  function automatic int f_next(input int holder, input int last, input logic [2:0] r);
    int idx;
    if (holder >= 0 && r[holder]) return holder;
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [2:0] f_vec(input int holder);
    logic [2:0] v;
    v = 3'b000;
    if (holder >= 0) v[holder] = 1'b1;
    return v;
  endfunction

  // Model advances on each sampled edge; reset forces it idle with pointer 2.
  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_holder <= -1;
      m_last   <= 2;
    end else begin
      m_holder <= f_next(m_holder, m_last, req);
      if (f_next(m_holder, m_last, req) >= 0)
        m_last <= f_next(m_holder, m_last, req);
    end
  end

  // Request value sampled at the most recent edge.
  always @(posedge clk) req_prev <= req;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycle_checks(input string tag);
    chk({tag, "_model"}, grant, f_vec(m_holder));
    chk({tag, "_onehot0"}, {2'b00, $onehot0(grant)}, 3'b001);
    chk({tag, "_reqgate"}, grant & ~req_prev, 3'b000);
  endtask

  // Directed step: apply req for 10 cycles, expect a steady grant value.
  task automatic step(input logic [2:0] r, input logic [2:0] exp, input string tag);
    @(negedge clk);
    res_n = 1'b1;
    req = r;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk(tag, grant, exp);
      cycle_checks(tag);
    end
  endtask

  // Random step: apply req for n cycles, compare against the model only.
  task automatic rstep(input logic [2:0] r, input int n);
    @(negedge clk);
    req = r;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      cycle_checks("rand");
    end
  endtask

  initial begin
    // Reset held with no requests.
    res_n = 1'b0;
    req = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle", grant, 3'b000);

    // Release with all requesting: requester 0 first.
    step(3'b111, 3'b001, "release_111");
    step(3'b110, 3'b010, "handover_110");
    step(3'b100, 3'b100, "handover_100");

    // Lock and wrap-around sequence.
    step(3'b001, 3'b001, "wrap_001");
    step(3'b010, 3'b010, "move_010");
    step(3'b110, 3'b010, "nopreempt_110");
    step(3'b011, 3'b010, "nopreempt_011");
    step(3'b101, 3'b100, "rotate_101");

    // Idle, then rotation from last grant 0.
    step(3'b000, 3'b000, "idle_000");
    step(3'b001, 3'b001, "setup_last0");
    step(3'b000, 3'b000, "idle_again");

    // Request pulse between edges must not be seen.
    @(negedge clk);
    #1 req = 3'b001;
    #2 req = 3'b000;
    @(posedge clk);
    #1;
    chk("glitch_unseen", grant, 3'b000);

    step(3'b011, 3'b010, "idle_last0_011");

    // Reset asserted mid-grant clears grants before the next edge.
    @(negedge clk);
    #2 res_n = 1'b0;
    #1;
    chk("async_reset", grant, 3'b000);
    @(posedge clk);
    #1;
    chk("reset_held", grant, 3'b000);
    step(3'b111, 3'b001, "rerelease_111");

    // Randomized requests against the reference model.
    for (int i = 0; i < 120; i++) begin
      rstep(3'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
    end

    // One random reset in the middle of traffic, then more traffic.
    @(negedge clk);
    #3 res_n = 1'b0;
    #1;
    chk("rand_reset", grant, 3'b000);
    @(negedge clk);
    res_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rstep(3'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
